// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM state type and request payload for the SRAM RW-port arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_rw_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_en,
    output logic [NUM_REQ-1:0]         o_grant_c,
    output logic [$clog2(NUM_REQ)-1:0] o_gidx_c
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] r_ptr;
    logic            w_any;

    // base + off modulo NUM_REQ; both operands are below NUM_REQ
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    always_comb begin
        w_any     = 1'b0;
        o_gidx_c  = '0;
        o_grant_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_any && i_req[wrap_idx(r_ptr, k)]) begin
                w_any    = 1'b1;
                o_gidx_c = wrap_idx(r_ptr, k);
            end
        end
        if (i_en && w_any) begin
            o_grant_c[o_gidx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|o_grant_c) begin
            r_ptr <= wrap_idx(o_gidx_c, 1);
        end
    end

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Shares SRAM RW port 0 among NUM_REQ requesters; optional post-reset array fill.
module sram_rw_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned           NUM_REQ       = 2,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*NUM_WMASKS-1:0]    req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             init_done,
    output logic                             sram_csb0,
    output logic                             sram_web0,
    output logic [NUM_WMASKS-1:0]            sram_wmask0,
    output logic [ADDR_WIDTH-1:0]            sram_addr0,
    output logic [DATA_WIDTH-1:0]            sram_din0,
    input  logic [DATA_WIDTH-1:0]            sram_dout0
);

    localparam int unsigned           ID_W      = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_p1_valid;
    logic [ID_W-1:0]       r_p1_id;
    logic                  r_web;
    logic [NUM_WMASKS-1:0] r_wmask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    req_t                  w_req [NUM_REQ];
    req_t                  w_sel;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gidx;
    logic                  w_issue;
    logic                  w_rd;
    logic                  w_arb_en;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_req[i] = '{we:    req_we[i],
                         wmask: req_wmask[i*NUM_WMASKS +: NUM_WMASKS],
                         addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                         wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    assign w_sel     = w_req[w_gidx];
    assign w_arb_en  = rst_n && (r_state == ST_RUN);
    assign req_ready = w_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req_valid),
        .i_en      (w_arb_en),
        .o_grant_c (w_grant),
        .o_gidx_c  (w_gidx)
    );

    // Next state and the combinational SRAM drive; idle cycles replay the last command fields
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_rd        = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = r_web;
        sram_wmask0 = r_wmask;
        sram_addr0  = r_addr;
        sram_din0   = r_din;
        if (rst_n) begin
            case (r_state)
                ST_INIT: begin
                    w_issue     = 1'b1;
                    sram_csb0   = 1'b0;
                    sram_web0   = 1'b0;
                    sram_wmask0 = '1;
                    sram_addr0  = r_init_cnt;
                    sram_din0   = INIT_VALUE;
                    if (r_init_cnt == LAST_ADDR) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (|w_grant) begin
                        w_issue     = 1'b1;
                        w_rd        = ~w_sel.we;
                        sram_csb0   = 1'b0;
                        sram_web0   = ~w_sel.we;
                        sram_wmask0 = w_sel.wmask;
                        sram_addr0  = w_sel.addr;
                        sram_din0   = w_sel.wdata;
                    end
                end
            endcase
        end
    end

    // State, init counter, held SRAM command and the two-stage read return path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_init_cnt <= '0;
            r_p1_valid <= 1'b0;
            r_p1_id    <= '0;
            r_web      <= 1'b1;
            r_wmask    <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            init_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            init_done <= (w_state_nxt == ST_RUN);
            if (r_state == ST_INIT && r_init_cnt != LAST_ADDR) begin
                r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
            end
            if (w_issue) begin
                r_web   <= sram_web0;
                r_wmask <= sram_wmask0;
                r_addr  <= sram_addr0;
                r_din   <= sram_din0;
            end
            r_p1_valid <= w_rd;
            r_p1_id    <= w_gidx;
            rsp_valid  <= r_p1_valid ? (NUM_REQ'(1) << r_p1_id) : '0;
            if (r_p1_valid) begin
                rsp_rdata <= sram_dout0;
            end
        end
    end

endmodule
